// File: rtl/desc_ctrl.sv
// desc_ctrl: descriptor-chain controller. Walks a linked list of 4-word
// descriptors over a read-only Wishbone master and hands each one to a data engine.
// Optional build macro: DESC_CTRL_ACK_TIMEOUT_EN. When it is defined, a beat
// that gets no ack or err for 255 strobe cycles is treated as a bus error.
module desc_ctrl (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic        append,
  input  logic        ndar_dirty,
  input  logic [31:3] ndar,
  input  logic        wb_int_clear,
  output logic        ndar_dirty_clear,
  output logic        append_clear,
  output logic        busy,
  output logic [31:0] dar,
  output logic [7:0]  csr,
  output logic        wb_int_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:3] desc_src,
  output logic [31:3] desc_dst,
  output logic [15:0] desc_len,
  input  logic        eng_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4,
    RECHK = 3'd5,
    ERROR = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:3] dar_q;
  logic [31:3] next_q;
  logic        end_q;
  logic        irq_q;
  logic        bus_err;
  logic        chain_end;
  logic [1:0]  beat;
  logic        bus_active;
  logic        beat_err;
  logic        beat_ack;
  logic        timeout;
  logic        start;
  logic        unused_dat;

  assign bus_active = (state == FETCH) || (state == RECHK);
  assign beat_err   = bus_active & (wbm_err_i | timeout);
  assign beat_ack   = bus_active & wbm_ack_i & ~beat_err;
  assign start      = (state == IDLE) & enable & ndar_dirty;
  assign dar        = {dar_q, 3'b000};
  assign csr        = {bus_err, chain_end, 3'b000, state};
  assign wbm_adr_o  = {dar_q, 3'b000} + {28'd0, beat, 2'b00};
  assign unused_dat = ^wbm_dat_i[2:1];

`ifdef DESC_CTRL_ACK_TIMEOUT_EN
  logic [7:0] ack_cnt;

  // the 255th strobe cycle without a response is the one that gives up
  assign timeout = bus_active & ~wbm_ack_i & ~wbm_err_i & (ack_cnt == 8'd254);

  // count strobe cycles of the current beat, restarting on every response
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      ack_cnt <= 8'd0;
    else if (!bus_active || wbm_ack_i || wbm_err_i)
      ack_cnt <= 8'd0;
    else
      ack_cnt <= ack_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  // next-state decode; a disabled channel still finishes an in-flight beat or engine job
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        if (beat_err)                      state_next = ERROR;
        else if (beat_ack && !enable)      state_next = IDLE;
        else if (beat_ack && beat == 2'd3) state_next = ISSUE;
      end
      ISSUE: begin
        if (desc_ready)   state_next = WAIT;
        else if (!enable) state_next = IDLE;
      end
      WAIT: begin
        if (eng_done) begin
          if (!enable)    state_next = IDLE;
          else if (end_q) state_next = HALT;
          else            state_next = FETCH;
        end
      end
      HALT: begin
        if (!enable)     state_next = IDLE;
        else if (append) state_next = RECHK;
      end
      RECHK: begin
        if (beat_err) state_next = ERROR;
        else if (beat_ack) begin
          if (!enable)          state_next = IDLE;
          else if (wbm_dat_i[0]) state_next = HALT;
          else                  state_next = FETCH;
        end
      end
      ERROR:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // outputs decoded from state; the consume pulses fire only on the accepting cycle
  always_comb begin
    busy             = 1'b0;
    wbm_cyc_o        = 1'b0;
    wbm_stb_o        = 1'b0;
    desc_valid       = 1'b0;
    ndar_dirty_clear = 1'b0;
    append_clear     = 1'b0;
    case (state)
      FETCH, RECHK: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      ISSUE: begin
        busy       = 1'b1;
        desc_valid = 1'b1;
      end
      WAIT:    busy = 1'b1;
      IDLE:    ndar_dirty_clear = enable & ndar_dirty & ~wb_rst_i;
      HALT:    append_clear = enable & append & ~wb_rst_i;
      default: ;
    endcase
  end

  // descriptor address, beat counter, latched descriptor words and status flags
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dar_q     <= '0;
      next_q    <= '0;
      end_q     <= 1'b0;
      irq_q     <= 1'b0;
      beat      <= 2'd0;
      bus_err   <= 1'b0;
      chain_end <= 1'b0;
      desc_src  <= '0;
      desc_dst  <= '0;
      desc_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dar_q     <= ndar;
            beat      <= 2'd0;
            chain_end <= 1'b0;
            bus_err   <= 1'b0;
          end
        end
        FETCH: begin
          if (beat_err)
            bus_err <= 1'b1;
          else if (beat_ack) begin
            case (beat)
              2'd0: begin
                next_q <= wbm_dat_i[31:3];
                end_q  <= wbm_dat_i[0];
              end
              2'd1: begin
                irq_q    <= wbm_dat_i[16];
                desc_len <= wbm_dat_i[15:0];
              end
              2'd2:    desc_src <= wbm_dat_i[31:3];
              default: desc_dst <= wbm_dat_i[31:3];
            endcase
            beat <= beat + 2'd1;
          end
        end
        WAIT: begin
          if (eng_done && enable) begin
            if (end_q)
              chain_end <= 1'b1;
            else begin
              dar_q <= next_q;
              beat  <= 2'd0;
            end
          end
        end
        HALT: begin
          if (enable && append) beat <= 2'd0;
        end
        RECHK: begin
          if (beat_err)
            bus_err <= 1'b1;
          else if (beat_ack) begin
            next_q <= wbm_dat_i[31:3];
            end_q  <= wbm_dat_i[0];
            if (enable && !wbm_dat_i[0]) begin
              dar_q     <= wbm_dat_i[31:3];
              beat      <= 2'd0;
              chain_end <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // sticky interrupt; a clear in the same cycle as a set wins
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wb_int_o <= 1'b0;
    else if (wb_int_clear)
      wb_int_o <= 1'b0;
    else if (state == WAIT && eng_done && irq_q)
      wb_int_o <= 1'b1;
  end

endmodule

// File: tb/tb_desc_ctrl.sv
// tb_desc_ctrl: directed bench for desc_ctrl with a memory-backed Wishbone
// slave, a simple data-engine model and a scoreboard for bus beats and descriptors.
module tb_desc_ctrl;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dar;
  } beat_t;

  typedef struct {
    logic [31:3] src;
    logic [31:3] dst;
    logic [15:0] len;
    int          cycles;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        append;
  logic        ndar_dirty;
  logic [31:3] ndar;
  logic        main_clr;
  logic        eng_clr;
  logic        int_clear;
  logic        ndar_dirty_clear;
  logic        append_clear;
  logic        busy;
  logic [31:0] dar;
  logic [7:0]  csr;
  logic        wb_int_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:3] desc_src;
  logic [31:3] desc_dst;
  logic [15:0] desc_len;
  logic        eng_done;

  logic [31:0] mem [logic [31:0]];
  beat_t       exp_beats [$];
  desc_t       exp_descs [$];

  int errors = 0;
  int checks = 0;
  int sb_errors = 0;
  int sb_checks = 0;

  int ack_wait = 0;
  int withhold = 0;
  int err_on_beat = -1;
  int beat_no = 0;
  int wait_cnt = 0;
  int ready_delay = 0;
  int done_delay = 2;
  int clear_on_done = 0;
  int vcnt = 0;
  int done_cnt = 0;
  int valid_seen = 0;
  int stb_run = 0;
  int last_run = 0;

  assign int_clear = main_clr | eng_clr;

  always #5 clk = ~clk;

  desc_ctrl dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .enable           (enable),
    .append           (append),
    .ndar_dirty       (ndar_dirty),
    .ndar             (ndar),
    .wb_int_clear     (int_clear),
    .ndar_dirty_clear (ndar_dirty_clear),
    .append_clear     (append_clear),
    .busy             (busy),
    .dar              (dar),
    .csr              (csr),
    .wb_int_o         (wb_int_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_src         (desc_src),
    .desc_dst         (desc_dst),
    .desc_len         (desc_len),
    .eng_done         (eng_done)
  );

  // Wishbone slave: answers each strobe from mem after ack_wait cycles, or injects an error
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (!rst && wbm_cyc_o && wbm_stb_o) begin
      if (wait_cnt < ack_wait)
        wait_cnt++;
      else begin
        wait_cnt = 0;
        if (withhold == 0) begin
          beat_no++;
          if (beat_no == err_on_beat)
            wbm_err_i = 1'b1;
          else begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = mem[wbm_adr_o];
          end
        end
      end
    end else
      wait_cnt = 0;
  end

  // data engine: accepts after ready_delay valid cycles, reports done after done_delay
  always @(negedge clk) begin
    eng_done = 1'b0;
    eng_clr  = 1'b0;
    if (rst) begin
      desc_ready = 1'b0;
      vcnt       = 0;
      done_cnt   = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          eng_done = 1'b1;
          if (clear_on_done != 0) eng_clr = 1'b1;
        end
      end
      if (desc_valid) begin
        if (vcnt == ready_delay) begin
          desc_ready = 1'b1;
          vcnt       = 0;
          done_cnt   = done_delay;
        end else begin
          desc_ready = 1'b0;
          vcnt++;
        end
      end else begin
        desc_ready = 1'b0;
        vcnt       = 0;
      end
    end
  end

  task automatic sbCheck(input string name, input logic [31:0] actual, input logic [31:0] expected);
    sb_checks++;
    if (actual !== expected) begin
      sb_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // monitor: pops the scoreboard on every acked beat and every descriptor handshake
  logic [31:3] held_src;
  logic [31:3] held_dst;
  logic [15:0] held_len;
  int          held_cycles = 0;
  logic        valid_prev = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    desc_t d;
    #1;
    if (rst) begin
      valid_prev = 1'b0;
      stb_run    = 0;
    end else begin
      if (wbm_cyc_o && wbm_stb_o) begin
        stb_run++;
        if (wbm_ack_i) begin
          stb_run = 0;
          if (exp_beats.size() == 0) begin
            sb_checks++;
            sb_errors++;
            $display("[TB] FAIL beat_unexpected: got adr %h, expected no beat", wbm_adr_o);
          end else begin
            b = exp_beats.pop_front();
            sbCheck("beat_adr", wbm_adr_o, b.adr);
            sbCheck("beat_dar", dar, b.dar);
          end
        end
      end else begin
        if (stb_run > 0) last_run = stb_run;
        stb_run = 0;
      end
      if (desc_valid) begin
        valid_seen++;
        if (!valid_prev) begin
          held_src    = desc_src;
          held_dst    = desc_dst;
          held_len    = desc_len;
          held_cycles = 1;
        end else begin
          held_cycles++;
          sbCheck("src_stable", {3'b000, desc_src}, {3'b000, held_src});
          sbCheck("dst_stable", {3'b000, desc_dst}, {3'b000, held_dst});
          sbCheck("len_stable", {16'd0, desc_len}, {16'd0, held_len});
        end
        if (desc_ready) begin
          if (exp_descs.size() == 0) begin
            sb_checks++;
            sb_errors++;
            $display("[TB] FAIL desc_unexpected: got src %h, expected no descriptor", desc_src);
          end else begin
            d = exp_descs.pop_front();
            sbCheck("desc_src", {3'b000, desc_src}, {3'b000, d.src});
            sbCheck("desc_dst", {3'b000, desc_dst}, {3'b000, d.dst});
            sbCheck("desc_len", {16'd0, desc_len}, {16'd0, d.len});
            sbCheck("valid_cycles", held_cycles, d.cycles);
          end
        end
      end
      valid_prev = desc_valid;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic writeDesc(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    mem[base]         = w0;
    mem[base + 32'd4] = w1;
    mem[base + 32'd8] = w2;
    mem[base + 32'd12] = w3;
  endtask

  task automatic expectBeats(input logic [31:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.adr = base + 32'(4 * i);
      b.dar = base;
      exp_beats.push_back(b);
    end
  endtask

  task automatic expectDesc(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len, input int cycles);
    desc_t d;
    d.src    = src[31:3];
    d.dst    = dst[31:3];
    d.len    = len;
    d.cycles = cycles;
    exp_descs.push_back(d);
  endtask

  task automatic applyStimulus(input logic [31:0] head);
    @(negedge clk);
    ndar       = head[31:3];
    enable     = 1'b1;
    ndar_dirty = 1'b1;
    #1 checkOutput("ndar_dirty_clear_pulse", ndar_dirty_clear, 1);
    @(negedge clk);
    ndar_dirty = 1'b0;
    #1 checkOutput("ndar_dirty_clear_low", ndar_dirty_clear, 0);
  endtask

  task automatic pulseAppend();
    @(negedge clk);
    append = 1'b1;
    #1 checkOutput("append_clear_pulse", append_clear, 1);
    @(negedge clk);
    append = 1'b0;
    #1 checkOutput("append_clear_low", append_clear, 0);
  endtask

  task automatic clearInt();
    @(negedge clk);
    main_clr = 1'b1;
    @(negedge clk);
    main_clr = 1'b0;
    #1 checkOutput("wb_int_cleared", wb_int_o, 0);
  endtask

  task automatic waitState(input logic [2:0] st, input int limit, input string name);
    int n = 0;
    while (csr[2:0] != st && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (csr[2:0] != st) begin
      errors++;
      $display("[TB] FAIL %s: state %0d after %0d cycles, expected %0d", name, csr[2:0], n, st);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vs;
    rst = 1'b1; enable = 1'b0; append = 1'b0; ndar_dirty = 1'b0;
    ndar = '0; main_clr = 1'b0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    desc_ready = 1'b0; eng_done = 1'b0; eng_clr = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_dar", dar, 0);
    checkOutput("rst_csr", csr, 0);
    checkOutput("rst_wb_int", wb_int_o, 0);
    checkOutput("rst_cyc", wbm_cyc_o, 0);
    checkOutput("rst_stb", wbm_stb_o, 0);
    checkOutput("rst_valid", desc_valid, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // single END descriptor with IRQ
    writeDesc(32'h1000, 32'h0000_0001, 32'h0001_0040, 32'h0000_5000, 32'h0000_6000);
    expectBeats(32'h1000, 4);
    expectDesc(32'h5000, 32'h6000, 16'h0040, 1);
    applyStimulus(32'h1000);
    waitState(3'd4, 200, "single_halt");
    checkOutput("single_csr", csr, 32'h44);
    checkOutput("single_wb_int", wb_int_o, 1);
    checkOutput("single_dar", dar, 32'h1000);
    checkOutput("single_busy", busy, 0);
    checkOutput("single_len", desc_len, 32'h40);
    clearInt();

    // two-descriptor chain, slow slave, engine accepts after 3 cycles
    writeDesc(32'h1000, 32'h0000_2000, 32'h0000_0080, 32'h0000_7000, 32'h0000_8000);
    writeDesc(32'h2000, 32'h0000_0001, 32'h0001_0010, 32'h0000_9000, 32'h0000_A000);
    expectBeats(32'h1000, 4);
    expectBeats(32'h2000, 4);
    expectDesc(32'h7000, 32'h8000, 16'h0080, 4);
    expectDesc(32'h9000, 32'hA000, 16'h0010, 4);
    ack_wait = 1;
    ready_delay = 3;
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(32'h1000);
    waitState(3'd4, 300, "chain_halt");
    checkOutput("chain_csr", csr, 32'h44);
    checkOutput("chain_dar", dar, 32'h2000);
    checkOutput("chain_wb_int", wb_int_o, 1);
    ack_wait = 0;
    ready_delay = 0;
    clearInt();

    // append with END=0 on the recheck read, then append with END=1
    writeDesc(32'h3000, 32'h0000_0001, 32'h0000_0020, 32'h0000_B000, 32'h0000_C000);
    mem[32'h2000] = 32'h0000_3000;
    expectBeats(32'h2000, 1);
    expectBeats(32'h3000, 4);
    expectDesc(32'hB000, 32'hC000, 16'h0020, 1);
    pulseAppend();
    waitState(3'd4, 200, "append_halt");
    checkOutput("append_dar", dar, 32'h3000);
    checkOutput("append_csr", csr, 32'h44);
    checkOutput("append_no_irq", wb_int_o, 0);
    expectBeats(32'h3000, 1);
    pulseAppend();
    waitState(3'd4, 50, "recheck_end_halt");
    checkOutput("recheck_end_dar", dar, 32'h3000);
    checkOutput("recheck_end_csr", csr, 32'h44);

    // bus error on the third beat
    vs = valid_seen;
    err_on_beat = beat_no + 3;
    expectBeats(32'h1000, 2);
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(32'h1000);
    waitState(3'd6, 50, "err_state");
    checkOutput("err_cyc_dropped", wbm_cyc_o, 0);
    checkOutput("err_csr", csr, 32'h86);
    repeat (3) @(negedge clk);
    #1 checkOutput("err_holds", csr, 32'h86);
    err_on_beat = -1;
    enable = 1'b0;
    @(negedge clk);
    #1 checkOutput("err_to_idle", csr, 32'h80);
    checkOutput("err_no_valid", valid_seen, vs);

    // disable while waiting for the engine
    done_delay = 8;
    expectBeats(32'h3000, 4);
    expectDesc(32'hB000, 32'hC000, 16'h0020, 1);
    applyStimulus(32'h3000);
    checkOutput("restart_clears_err", csr, 32'h01);
    waitState(3'd3, 50, "wait_state");
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 checkOutput("busy_in_wait", busy, 1);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("busy_after_done", busy, 0);
    checkOutput("wait_disable_csr", csr, 32'h00);
    done_delay = 2;

    // clear in the same cycle as the interrupt set: interrupt lost
    writeDesc(32'h1000, 32'h0000_0001, 32'h0001_0040, 32'h0000_5000, 32'h0000_6000);
    expectBeats(32'h1000, 4);
    expectDesc(32'h5000, 32'h6000, 16'h0040, 1);
    clear_on_done = 1;
    applyStimulus(32'h1000);
    waitState(3'd4, 200, "prio_halt");
    checkOutput("prio_wb_int_lost", wb_int_o, 0);
    checkOutput("prio_csr", csr, 32'h44);
    clear_on_done = 0;

`ifdef DESC_CTRL_ACK_TIMEOUT_EN
    // ack withheld: timeout after 255 strobe cycles
    withhold = 1;
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(32'h1000);
    waitState(3'd6, 400, "timeout_state");
    @(negedge clk);
    #1 checkOutput("timeout_stb_cycles", last_run, 255);
    checkOutput("timeout_csr", csr, 32'h86);
    withhold = 0;
`endif

    // reset asserted in the middle of a beat
    withhold = 1;
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(32'h1000);
    @(negedge clk);
    #1 checkOutput("midrst_cyc_before", wbm_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_cyc", wbm_cyc_o, 0);
    checkOutput("midrst_stb", wbm_stb_o, 0);
    checkOutput("midrst_valid", desc_valid, 0);
    checkOutput("midrst_csr", csr, 0);
    checkOutput("midrst_dar", dar, 0);
    checkOutput("midrst_len", desc_len, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    withhold = 0;

    @(negedge clk);
    #2;
    checkOutput("beats_drained", exp_beats.size(), 0);
    checkOutput("descs_drained", exp_descs.size(), 0);
    errors += sb_errors;
    checks += sb_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/desc_ctrl.md
DESC_CTRL -- requirements
Module: desc_ctrl

Interface
REQ-001 SHALL have port wb_clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port wb_rst_i, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1: channel run enable from the register block.
REQ-004 SHALL have port append, input, 1: software appended descriptors to the chain.
REQ-005 SHALL have port ndar_dirty, input, 1: a new chain head is present on ndar.
REQ-006 SHALL have port ndar, input, [31:3]: chain head descriptor address.
REQ-007 SHALL have port wb_int_clear, input, 1: one-cycle pulse that clears wb_int_o.
REQ-008 SHALL have port ndar_dirty_clear, output, 1: one-cycle pulse when ndar is consumed.
REQ-009 SHALL have port append_clear, output, 1: one-cycle pulse when append is consumed.
REQ-010 SHALL have port busy, output, 1: high in FETCH, ISSUE, WAIT and RECHK.
REQ-011 SHALL have port dar, output, 32: address of the current descriptor, with [2:0] always 0.
REQ-012 SHALL have port csr, output, 8: status {bus_err, chain_end, 3'b0, state[2:0]}.
REQ-013 SHALL have port wb_int_o, output, 1: sticky completion interrupt.
REQ-014 SHALL have port wbm_cyc_o, output, 1: Wishbone master cycle (read-only master).
REQ-015 SHALL have port wbm_stb_o, output, 1: Wishbone master strobe.
REQ-016 SHALL have port wbm_adr_o, output, 32: word address of the descriptor being read.
REQ-017 SHALL have port wbm_dat_i, input, 32: read data.
REQ-018 SHALL have port wbm_ack_i, input, 1: read acknowledge.
REQ-019 SHALL have port wbm_err_i, input, 1: bus error.
REQ-020 SHALL have port desc_valid, output, 1: descriptor is offered to the data engine.
REQ-021 SHALL have port desc_ready, input, 1: the data engine accepts the descriptor.
REQ-022 SHALL have port desc_src, output, [31:3]: source address.
REQ-023 SHALL have port desc_dst, output, [31:3]: destination address.
REQ-024 SHALL have port desc_len, output, 16: transfer length in bytes.
REQ-025 SHALL have port eng_done, input, 1: one-cycle pulse when the data engine has finished the issued descriptor.

Function
REQ-026 SHALL use a descriptor of 4 words at dar: w0 = {next[31:3], 2'b0, END}; w1 = {15'b0, IRQ, len[15:0]}; w2 = {src[31:3], 3'b0}; w3 = {dst[31:3], 3'b0}.
REQ-027 SHALL implement the states IDLE=0, FETCH=1, ISSUE=2, WAIT=3, HALT=4, RECHK=5 and ERROR=6, encoded in csr[2:0].
REQ-028 SHALL, in IDLE with enable=1 and ndar_dirty=1, load dar<={ndar,3'b0}, pulse ndar_dirty_clear in the same cycle, clear chain_end, and enter FETCH.
REQ-029 SHALL, in FETCH, perform 4 single reads at dar+0, +4, +8 and +12, holding cyc and stb high until ack, with at most 1 idle cycle between beats, latch each word on its ack, and enter ISSUE after the 4th ack.
REQ-030 SHALL, in ISSUE, hold desc_valid=1 with stable desc_* outputs until desc_ready=1, then enter WAIT; a transfer completes when valid and ready are both high in the same cycle.
REQ-031 SHALL, in WAIT on eng_done: set wb_int_o if IRQ=1; then, if END=1, set chain_end and enter HALT; else load dar<={next,3'b0} and enter FETCH.
REQ-032 SHALL, in HALT with append=1, pulse append_clear and enter RECHK, which re-reads only w0 at dar; if END=0 on that read it loads dar<=next and enters FETCH, otherwise it returns to HALT.
REQ-033 SHALL, on enable=0: leave IDLE and HALT for IDLE immediately; in FETCH or RECHK complete the outstanding beat and then go to IDLE; in ISSUE go to IDLE and drop desc_valid; in WAIT go to IDLE on eng_done.
REQ-034 SHALL, on wbm_err_i during any beat, drop cyc/stb, set bus_err, and enter ERROR; ERROR exits to IDLE only when enable=0, and bus_err clears on the next IDLE-to-FETCH start.
REQ-035 SHALL give wb_int_clear priority over a same-cycle set of wb_int_o, so that an interrupt set in the same cycle is lost.
REQ-036 SHALL ignore ndar_dirty outside IDLE, leaving it pending, and SHALL ignore append outside HALT, leaving it pending.

Reset
REQ-037 SHALL, on reset, enter IDLE and drive all outputs to 0, including dar, csr, wb_int_o, cyc, stb and desc_valid.
REQ-038 SHALL, on reset asserted mid-cycle, drop cyc/stb and desc_valid asynchronously and not latch the partial descriptor.

Configuration
REQ-039 SHALL, with DESC_CTRL_ACK_TIMEOUT_EN defined, use an 8-bit per-beat counter so that 255 cycles of stb without ack or err is treated exactly as wbm_err_i (REQ-034); without the macro, it waits for ack indefinitely and has no counter.

Verification
REQ-040 SHALL cover: ndar=0x1000>>3, enable=1, ndar_dirty=1, w0=0x00000001, w1=0x00010040 -> reads at 0x1000/4/8/C, desc_len=0x40, ndar_dirty_clear pulse, wb_int_o=1 after eng_done, state HALT, csr=0x44.
REQ-041 SHALL cover: a 2-descriptor chain at 0x1000 then 0x2000 with desc_ready delayed 3 cycles -> desc_valid held 4 cycles with stable outputs, dar=0x2000 during the second fetch.
REQ-042 SHALL cover: HALT at 0x2000, w0 rewritten to next=0x3000 with END=0, append=1 -> append_clear pulse, single read at 0x2000, then fetch at 0x3000.
REQ-043 SHALL cover: wbm_err_i on the 3rd beat -> cyc=0 next cycle, csr=0x86, desc_valid never asserted, IDLE after enable=0.
REQ-044 SHALL cover: enable=0 during WAIT -> busy stays 1 until eng_done, then IDLE with busy=0.
REQ-045 SHALL cover: with DESC_CTRL_ACK_TIMEOUT_EN defined and ack withheld -> ERROR entered after 255 stb cycles.
